flash_ctrl: RTL and testbench
=============================

// Module: flash_ctrl
// PURPOSE
//  Memory-bus responder for the 16-bit parallel NOR flash on the FSE bus, sitting beside sram_ctrl.
//  Accepts word requests from the CPU mem_* port, runs timed async flash cycles (two halfwords per
//  word), and returns read data tagged with the request id. Gives the boot path a read-only view of flash.
// PARAMETERS
//  ADDR_W   22  flash halfword-address width (flash_a); mem word address uses ADDR_W-1 LSBs
//  WAIT_RD  3   cycles flash_oe_n held low per halfword read (>=1; 3 = 120 ns at 25 MHz)
//  WAIT_WR  3   cycles flash_we_n held low per halfword program (>=1; MEM_FLASH_WRITE_EN only)
// PORTS
//  clock              in   1      system clock (25 MHz)
//  rst                in   1      synchronous, active-high reset
//  mem_waitrequest    out  1      1 = request not accepted this cycle
//  mem_id             in   2      request id, echoed on mem_readdataid
//  mem_address        in   30     word address
//  mem_read           in   1      read request
//  mem_write          in   1      write request
//  mem_writedata      in   32     write data
//  mem_writedatamask  in   4      byte enables, [3] = bits 31:24
//  mem_readdata       out  32     read data
//  mem_readdataid     out  2      id of mem_readdata; 0 = no data this cycle
//  flash_a            out  ADDR_W halfword address
//  flash_d_in         in   16     data from pad
//  flash_d_out        out  16     data to pad
//  flash_d_oe         out  1      pad output enable
//  flash_cs_n, flash_oe_n, flash_we_n  out 1  flash strobes, active low
// BEHAVIOUR
//  Reset: state IDLE; flash_cs_n/oe_n/we_n=1; flash_d_oe=0; mem_readdataid=0; readdata=0; flash_a=0.
//  mem_waitrequest = rst | (state != IDLE)  (combinational). Accept = (read|write) & !waitrequest.
//  Initiator never uses id 0 for reads and never asserts read & write together. If both are
//   asserted, the block performs the read and drops the write.
//  FSM: IDLE -> RD_HI -> RD_LO -> RESP -> IDLE.
//   WR path: IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> (next half | IDLE).
//  Read: flash_a = {addr[ADDR_W-2:0],0}. cs_n/oe_n low for WAIT_RD cycles; flash_d_in is sampled
//   into readdata[31:16] on the last cycle. Then flash_a LSB = 1 for WAIT_RD cycles, sampled into [15:0]
//   (big-endian). RESP: readdataid = id for exactly 1 cycle; oe_n/cs_n high.
//   Latency accept -> data = 2*WAIT_RD+1 cycles; next accept is possible in the cycle after RESP.
//  Down-counter: loads WAIT_RD-1 on phase entry; phase ends at 0; no wrap.
//  Address wrap: mem_address bits above ADDR_W-2 are ignored (flash aliases).
//  rst mid-cycle: next edge returns to IDLE, strobes go high, no readdataid is emitted for the lost request.
// CONFIGURATION
//  MEM_FLASH_WRITE_EN defined:
//   - Each halfword with any mask bit set is programmed; halves with no mask bit set are skipped.
//   - Unmasked bytes within a programmed half are driven 0xFF (program cannot set bits).
//   - WR_SETUP (1 cycle: cs_n=0, d_oe=1) -> WR_PULSE (WAIT_WR cycles: we_n=0) -> WR_HOLD (1 cycle: we_n=1, d_oe=1).
//   - High half is programmed first. Mask 0000 returns to IDLE the cycle after accept.
//   - Command sequences (unlock/program) are software's job.
//  MEM_FLASH_WRITE_EN undefined: write is accepted in 1 cycle, discarded; no flash activity; we_n
//   tied 1, d_oe tied 0.
// STRUCTURE
//  Shared include mem_if.h: mem_* widths (ID_W=2, ADDR=30, DATA=32, MASK=4) for sram_ctrl, blockram,
//   and this block. FSM state localparams stay local. No sub-module: counter and FSM are inline.
// TESTING
//  1 Flash model with 0x0000:0x1234, 0x0001:0xABCD; read addr 0, id 2 -> readdata 0x1234ABCD,
//    readdataid 2 exactly 7 cycles after accept (WAIT_RD=3).
//  2 Back-to-back reads ids 1,3 -> waitrequest high through RESP; second accept in cycle after
//    first RESP; both ids returned in order; readdataid 0 otherwise.
//  3 WAIT_RD=1 -> latency 3; oe_n low exactly 1 cycle per half; flash_a LSB toggles 0 -> 1.
//  4 rst pulsed in RD_LO -> strobes high the next cycle, no readdataid ever, then a new read completes.
//  5 WRITE_EN: write 0x11223344 mask 0100 -> one program, flash_a LSB=0, d_out=0xFF22,
//    we_n low 3 cycles; low half untouched.
//  6 no WRITE_EN: write mask 1111 -> waitrequest low next cycle, we_n stays 1, flash content unchanged.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// flash_ctrl_pkg
//   Shared memory-bus widths for the FSE-bus responders (sram_ctrl, blockram,
//   flash_ctrl). It also holds the helper that builds the program data for one
//   halfword.
// -----------------------------------------------------------------------------
package flash_ctrl_pkg;

    localparam int MEM_ID_W   = 2;
    localparam int MEM_ADDR_W = 30;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_MASK_W = 4;
    localparam int FLASH_D_W  = 16;

    // NOR programming can only clear bits, so an unmasked byte is driven as
    // 0xFF. This leaves that byte of the flash cell unchanged.
    function automatic logic [FLASH_D_W-1:0] prog_half(
        input logic [FLASH_D_W-1:0] data,
        input logic [1:0]           mask
    );
        return {mask[1] ? data[15:8] : 8'hFF,
                mask[0] ? data[7:0]  : 8'hFF};
    endfunction

endpackage

// File: rtl/flash_ctrl.sv
// -----------------------------------------------------------------------------
// flash_ctrl
//   Memory-bus responder for a 16-bit parallel NOR flash. The block accepts one
//   word request at a time. For each word it runs two timed asynchronous flash
//   cycles, high halfword first (big-endian). Read data is returned together
//   with the id of the request.
//
//   Build option: MEM_FLASH_WRITE_EN
//     defined   - writes program the masked halfwords
//                 (WR_SETUP -> WR_PULSE -> WR_HOLD for each halfword).
//     undefined - a write is accepted in one cycle and discarded. we_n is held
//                 at 1 and the pad output enable is held at 0.
//
// Ports
//   clock, rst          system clock; synchronous active-high reset
//   mem_waitrequest     1 = the request is not accepted this cycle
//   mem_id              request id, returned on mem_readdataid
//   mem_address         word address; bits above ADDR_W-2 are ignored
//   mem_read/mem_write  request strobes (a read wins if both are set)
//   mem_writedata/mask  write data and byte enables ([3] = bits 31:24)
//   mem_readdata        read data
//   mem_readdataid      id of mem_readdata; 0 = no data this cycle
//   flash_a             halfword address to the flash
//   flash_d_in/out/oe   data pad in/out and pad output enable
//   flash_cs_n/oe_n/we_n  flash strobes, active low
// -----------------------------------------------------------------------------
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 22,
    parameter int WAIT_RD = 3,
    parameter int WAIT_WR = 3
) (
    input  logic                  clock,
    input  logic                  rst,
    output logic                  mem_waitrequest,
    input  logic [MEM_ID_W-1:0]   mem_id,
    input  logic [MEM_ADDR_W-1:0] mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_DATA_W-1:0] mem_writedata,
    input  logic [MEM_MASK_W-1:0] mem_writedatamask,
    output logic [MEM_DATA_W-1:0] mem_readdata,
    output logic [MEM_ID_W-1:0]   mem_readdataid,
    output logic [ADDR_W-1:0]     flash_a,
    input  logic [FLASH_D_W-1:0]  flash_d_in,
    output logic [FLASH_D_W-1:0]  flash_d_out,
    output logic                  flash_d_oe,
    output logic                  flash_cs_n,
    output logic                  flash_oe_n,
    output logic                  flash_we_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HI,
        S_RD_LO,
        S_RESP,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    localparam int WAIT_MAX = (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
    localparam int CNT_W    = $clog2(WAIT_MAX) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(WAIT_RD - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [MEM_ID_W-1:0] id_q;
    logic                accept_rd;

    // The responder is busy in every state except IDLE. It is also busy while
    // reset is asserted.
    assign mem_waitrequest = rst | (state != S_IDLE);
    assign accept_rd       = mem_read & ~mem_waitrequest;

`ifdef MEM_FLASH_WRITE_EN
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WAIT_WR - 1);

    logic                 accept_wr;
    logic                 lo_pending;
    logic [FLASH_D_W-1:0] lo_data;

    assign accept_wr = mem_write & ~mem_read & ~mem_waitrequest;
`else
    // No write path: the strobe and the pad enable are held inactive.
    assign flash_we_n  = 1'b1;
    assign flash_d_oe  = 1'b0;
    assign flash_d_out = '0;
`endif

    // NOTE: every state register uses non-blocking assignment. All registers
    // then update together on the edge, whatever the order of the statements.
    always_ff @(posedge clock) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            id_q           <= '0;
            flash_a        <= '0;
            flash_cs_n     <= 1'b1;
            flash_oe_n     <= 1'b1;
            mem_readdata   <= '0;
            mem_readdataid <= '0;
`ifdef MEM_FLASH_WRITE_EN
            flash_we_n     <= 1'b1;
            flash_d_oe     <= 1'b0;
            flash_d_out    <= '0;
            lo_pending     <= 1'b0;
            lo_data        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_rd) begin
                        flash_a    <= {mem_address[ADDR_W-2:0], 1'b0};
                        flash_cs_n <= 1'b0;
                        flash_oe_n <= 1'b0;
                        cnt        <= RD_LOAD;
                        id_q       <= mem_id;
                        state      <= S_RD_HI;
                    end
`ifdef MEM_FLASH_WRITE_EN
                    else if (accept_wr) begin
                        // Program the high half first if it has any enabled
                        // byte. With mask 0000 the block stays in IDLE.
                        lo_data <= prog_half(mem_writedata[15:0], mem_writedatamask[1:0]);
                        if (|mem_writedatamask[3:2]) begin
                            flash_a     <= {mem_address[ADDR_W-2:0], 1'b0};
                            flash_d_out <= prog_half(mem_writedata[31:16], mem_writedatamask[3:2]);
                            lo_pending  <= |mem_writedatamask[1:0];
                            flash_cs_n  <= 1'b0;
                            flash_d_oe  <= 1'b1;
                            state       <= S_WR_SETUP;
                        end else if (|mem_writedatamask[1:0]) begin
                            flash_a     <= {mem_address[ADDR_W-2:0], 1'b1};
                            flash_d_out <= prog_half(mem_writedata[15:0], mem_writedatamask[1:0]);
                            lo_pending  <= 1'b0;
                            flash_cs_n  <= 1'b0;
                            flash_d_oe  <= 1'b1;
                            state       <= S_WR_SETUP;
                        end
                    end
`endif
                end

                // The counter is loaded on entry to each phase and counts down.
                // It never wraps: the phase ends in the cycle the counter is 0.
                S_RD_HI: begin
                    if (cnt == '0) begin
                        mem_readdata[31:16] <= flash_d_in;
                        flash_a[0]          <= 1'b1;
                        cnt                 <= RD_LOAD;
                        state               <= S_RD_LO;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_RD_LO: begin
                    if (cnt == '0) begin
                        mem_readdata[15:0] <= flash_d_in;
                        flash_cs_n         <= 1'b1;
                        flash_oe_n         <= 1'b1;
                        mem_readdataid     <= id_q;
                        state              <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_RESP: begin
                    mem_readdataid <= '0;
                    state          <= S_IDLE;
                end

`ifdef MEM_FLASH_WRITE_EN
                S_WR_SETUP: begin
                    flash_we_n <= 1'b0;
                    cnt        <= WR_LOAD;
                    state      <= S_WR_PULSE;
                end

                S_WR_PULSE: begin
                    if (cnt == '0) begin
                        flash_we_n <= 1'b1;
                        state      <= S_WR_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_WR_HOLD: begin
                    if (lo_pending) begin
                        flash_a[0]  <= 1'b1;
                        flash_d_out <= lo_data;
                        lo_pending  <= 1'b0;
                        state       <= S_WR_SETUP;
                    end else begin
                        flash_cs_n <= 1'b1;
                        flash_d_oe <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flash_ctrl
//   Self-checking bench for flash_ctrl. It has a behavioural NOR flash model
//   and a response scoreboard. The main DUT uses WAIT_RD=3. A second instance
//   uses WAIT_RD=1 for the short-latency case. The write tests follow
//   MEM_FLASH_WRITE_EN.
// -----------------------------------------------------------------------------
module tb_flash_ctrl;
    import flash_ctrl_pkg::*;

    localparam int ADDR_W  = 22;
    localparam int WAIT_RD = 3;
    localparam int LAT     = 2 * WAIT_RD + 1;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #20 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Main DUT (WAIT_RD = 3)
    logic        waitreq, rd = 0, wr = 0;
    logic [1:0]  id = 0, rdid;
    logic [29:0] addr = 0;
    logic [31:0] wdata = 0, rdata;
    logic [3:0]  wmask = 0;
    logic [21:0] fa;
    logic [15:0] d_in, d_out;
    logic        d_oe, cs_n, oe_n, we_n;

    // Fast DUT (WAIT_RD = 1)
    logic        b_waitreq, b_rd = 0;
    logic [1:0]  b_id = 0, b_rdid;
    logic [29:0] b_addr = 0;
    logic [31:0] b_rdata;
    logic [21:0] b_fa;
    logic [15:0] b_d_in, b_d_out;
    logic        b_d_oe, b_cs_n, b_oe_n, b_we_n;

    flash_ctrl #(.ADDR_W(ADDR_W), .WAIT_RD(WAIT_RD), .WAIT_WR(3)) u_dut (
        .clock(clock), .rst(rst), .mem_waitrequest(waitreq), .mem_id(id),
        .mem_address(addr), .mem_read(rd), .mem_write(wr), .mem_writedata(wdata),
        .mem_writedatamask(wmask), .mem_readdata(rdata), .mem_readdataid(rdid),
        .flash_a(fa), .flash_d_in(d_in), .flash_d_out(d_out), .flash_d_oe(d_oe),
        .flash_cs_n(cs_n), .flash_oe_n(oe_n), .flash_we_n(we_n)
    );

    flash_ctrl #(.ADDR_W(ADDR_W), .WAIT_RD(1), .WAIT_WR(3)) u_dut_fast (
        .clock(clock), .rst(rst), .mem_waitrequest(b_waitreq), .mem_id(b_id),
        .mem_address(b_addr), .mem_read(b_rd), .mem_write(1'b0), .mem_writedata(32'h0),
        .mem_writedatamask(4'h0), .mem_readdata(b_rdata), .mem_readdataid(b_rdid),
        .flash_a(b_fa), .flash_d_in(b_d_in), .flash_d_out(b_d_out), .flash_d_oe(b_d_oe),
        .flash_cs_n(b_cs_n), .flash_oe_n(b_oe_n), .flash_we_n(b_we_n)
    );

    // Flash model: 1k halfwords. Read data is driven only while cs_n and oe_n
    // are both low.
    logic [15:0] fm [0:1023];
    assign d_in   = (!cs_n && !oe_n)     ? fm[fa[9:0]]   : 16'hDEAD;
    assign b_d_in = (!b_cs_n && !b_oe_n) ? fm[b_fa[9:0]] : 16'hDEAD;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Response monitor and program monitor, sampled on the falling edge.
    int          n_resp = 0;
    int          we_run = 0, prog_cnt = 0, prog_len = 0, bad_addr = 0;
    logic [21:0] prog_addr = 0;
    logic [15:0] prog_data = 0;
    logic        d_oe_seen = 0;

    always @(negedge clock) begin
        exp_t e;
        if (!rst && rdid != 2'd0) begin
            n_resp++;
            if (sb.size() == 0) begin
                check("unexpected_resp_id", {30'd0, rdid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_id", {30'd0, rdid}, {30'd0, e.id});
                check("resp_data", rdata, e.data);
                check("resp_cycle", cyc, e.due);
            end
        end
        if (we_n == 1'b0) begin
            we_run++;
        end else if (we_run != 0) begin
            prog_cnt++;
            prog_len  = we_run;
            prog_addr = fa;
            prog_data = d_out;
            fm[fa[9:0]] = fm[fa[9:0]] & d_out;
            we_run = 0;
        end
        if (d_oe) d_oe_seen = 1'b1;
        if (!cs_n && fa[21:10] != 12'd0) bad_addr++;
    end

    // Drive one request and wait (bounded) for it to be accepted. The read's
    // expected response is pushed onto the scoreboard. acc = accept cycle.
    task automatic issue(input logic is_wr, input logic [29:0] a, input logic [1:0] i,
                         input logic [31:0] d, input logic [3:0] m,
                         input logic [31:0] exp_d, output int acc);
        int n = 0;
        exp_t e;
        @(negedge clock);
        addr = a; id = i; wdata = d; wmask = m; rd = !is_wr; wr = is_wr;
        while (waitreq && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (waitreq) check("accept_timeout", {31'd0, waitreq}, 32'd0);
        acc = cyc;
        if (!is_wr) begin
            e.id = i; e.data = exp_d; e.due = cyc + LAT;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (waitreq && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", {31'd0, waitreq}, 32'd0);
    endtask

    typedef struct {
        logic [29:0] addr;
        logic [1:0]  id;
        logic [31:0] exp;
    } rd_vec_t;

    initial begin : watchdog
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        rd_vec_t vecs [5];
        int acc, acc2, p0, r0;

        for (int i = 0; i < 1024; i++) fm[i] = 16'hFFFF;
        fm[0]     = 16'h1234; fm[1]     = 16'hABCD;
        fm[2]     = 16'h5A5A; fm[3]     = 16'h0F0F;
        fm[4]     = 16'hC0DE; fm[5]     = 16'hBEEF;
        fm[10'h3FE] = 16'h8001; fm[10'h3FF] = 16'h7FFE;

        vecs[0] = '{30'h0000_0000, 2'd2, 32'h1234ABCD};
        vecs[1] = '{30'h0000_0001, 2'd1, 32'h5A5A0F0F};
        vecs[2] = '{30'h0020_0000, 2'd3, 32'h1234ABCD};  // bit 21 is above the flash range: aliases word 0
        vecs[3] = '{30'h3FE0_0001, 2'd2, 32'h5A5A0F0F};  // upper bits ignored
        vecs[4] = '{30'h0000_01FF, 2'd1, 32'h80017FFE};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_waitreq", {31'd0, waitreq}, 32'd1);
        check("rst_strobes", {29'd0, cs_n, oe_n, we_n}, 32'd7);
        check("rst_d_oe", {31'd0, d_oe}, 32'd0);
        check("rst_rdid", {30'd0, rdid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_flash_a", {10'd0, fa}, 32'd0);
        rst = 1'b0;
        @(negedge clock);
        check("idle_waitreq", {31'd0, waitreq}, 32'd0);

        // Single reads from the table; latency and data are checked by the
        // scoreboard.
        foreach (vecs[k]) begin
            issue(1'b0, vecs[k].addr, vecs[k].id, 32'h0, 4'h0, vecs[k].exp, acc);
            drain();
        end

        // Back-to-back reads: the second is accepted in the cycle after the
        // first RESP.
        issue(1'b0, 30'd2, 2'd1, 32'h0, 4'h0, 32'hC0DEBEEF, acc);
        issue(1'b0, 30'd0, 2'd3, 32'h0, 4'h0, 32'h1234ABCD, acc2);
        check("b2b_accept_cycle", acc2, acc + LAT + 1);
        drain();

        // WAIT_RD = 1 instance: latency 3; oe_n is low for 1 cycle per half
        // and the address LSB goes 0 then 1.
        @(negedge clock);
        b_addr = 30'd0; b_id = 2'd1; b_rd = 1'b1;
        check("fast_waitreq", {31'd0, b_waitreq}, 32'd0);
        @(posedge clock);
        #1 b_rd = 1'b0;
        @(negedge clock);
        check("fast_hi", {30'd0, b_oe_n, b_fa[0]}, 32'b00);
        @(negedge clock);
        check("fast_lo", {30'd0, b_oe_n, b_fa[0]}, 32'b01);
        check("fast_lo_rdid", {30'd0, b_rdid}, 32'd0);
        @(negedge clock);
        check("fast_resp_oe_n", {31'd0, b_oe_n}, 32'd1);
        check("fast_resp_rdid", {30'd0, b_rdid}, 32'd1);
        check("fast_resp_data", b_rdata, 32'h1234ABCD);
        @(negedge clock);
        check("fast_after_rdid", {30'd0, b_rdid}, 32'd0);

        // Reset pulsed during RD_LO: strobes go high, the lost request is never
        // answered, and a later read still completes.
        issue(1'b0, 30'd1, 2'd2, 32'h0, 4'h0, 32'h5A5A0F0F, acc);
        while (cyc < acc + WAIT_RD + 1) @(negedge clock);
        check("rst_test_in_rd_lo", {31'd0, fa[0]}, 32'd1);
        sb.delete();
        r0 = n_resp;
        rst = 1'b1;
        @(negedge clock);
        check("midrst_strobes", {30'd0, cs_n, oe_n}, 32'd3);
        check("midrst_waitreq", {31'd0, waitreq}, 32'd1);
        rst = 1'b0;
        repeat (12) @(negedge clock);
        check("midrst_no_resp", n_resp, r0);
        issue(1'b0, 30'd0, 2'd3, 32'h0, 4'h0, 32'h1234ABCD, acc);
        drain();

`ifdef MEM_FLASH_WRITE_EN
        // Mask 0100: one program of the high half with the unmasked byte at
        // 0xFF; the low half is not touched.
        p0 = prog_cnt;
        issue(1'b1, 30'd8, 2'd0, 32'h11223344, 4'b0100, 32'h0, acc);
        wait_idle();
        check("wr1_prog_count", prog_cnt - p0, 32'd1);
        check("wr1_pulse_len", prog_len, 32'd3);
        check("wr1_addr", {10'd0, prog_addr}, 32'h10);
        check("wr1_data", {16'd0, prog_data}, 32'hFF22);
        check("wr1_lo_untouched", {16'd0, fm[10'h11]}, 32'hFFFF);
        issue(1'b0, 30'd8, 2'd1, 32'h0, 4'h0, 32'hFF22FFFF, acc);
        drain();

        // Full mask: both halves are programmed, the high half first.
        p0 = prog_cnt;
        issue(1'b1, 30'd9, 2'd0, 32'hA5A55A5A, 4'b1111, 32'h0, acc);
        wait_idle();
        check("wr2_prog_count", prog_cnt - p0, 32'd2);
        check("wr2_last_addr", {10'd0, prog_addr}, 32'h13);
        check("wr2_hi_cell", {16'd0, fm[10'h12]}, 32'hA5A5);
        issue(1'b0, 30'd9, 2'd2, 32'h0, 4'h0, 32'hA5A55A5A, acc);
        drain();

        // Mask 0000: back in IDLE in the cycle after accept, with no program.
        p0 = prog_cnt;
        issue(1'b1, 30'd10, 2'd0, 32'h12345678, 4'b0000, 32'h0, acc);
        @(negedge clock);
        check("wr0_waitreq", {31'd0, waitreq}, 32'd0);
        check("wr0_no_prog", prog_cnt, p0);

        // Mask 0001: only the low half is programmed.
        issue(1'b1, 30'd10, 2'd0, 32'h000000C3, 4'b0001, 32'h0, acc);
        wait_idle();
        check("wr3_addr", {10'd0, prog_addr}, 32'h15);
        issue(1'b0, 30'd10, 2'd3, 32'h0, 4'h0, 32'hFFFFFFC3, acc);
        drain();
`else
        // No write path: the write is accepted and dropped, with no flash
        // activity.
        p0 = prog_cnt;
        issue(1'b1, 30'd8, 2'd0, 32'h11223344, 4'b1111, 32'h0, acc);
        @(negedge clock);
        check("nowr_waitreq", {31'd0, waitreq}, 32'd0);
        check("nowr_no_prog", prog_cnt + we_run, p0);
        check("nowr_d_oe_never", {31'd0, d_oe_seen}, 32'd0);
        issue(1'b0, 30'd8, 2'd1, 32'h0, 4'h0, 32'hFFFFFFFF, acc);
        drain();
`endif

        check("flash_a_upper_zero", bad_addr, 32'd0);
        repeat (4) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
